// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU bus bridge to asynchronous SRAM with a UART MMIO window.
// Byte writes use read-modify-write; received UART bytes queue in a small FIFO.
module mem_ctrl #(
    parameter int         RXDEPTH   = 4,
    parameter logic [7:0] MMIO_PAGE = 8'hFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        i_re,
    input  logic        i_we,
    input  logic        i_be,
    output logic [15:0] o_rdata,
    output logic        o_rdy,
    output logic        o_ack,
    output logic        o_align_err,
    output logic [14:0] o_sram_addr,
    output logic [15:0] o_sram_dout,
    input  logic [15:0] i_sram_din,
    output logic        o_sram_we_n,
    output logic        o_sram_oe_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_uart_intr
);
    localparam int AW = $clog2(RXDEPTH);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, TXW, DONE} state_t;

    state_t        r_state, w_next;
    logic [15:0]   r_addr, r_wdata, r_cap, r_rdata;
    logic          r_be, r_mmio, r_ovf;
    logic [7:0]    r_fifo [RXDEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          w_accept, w_mmio, w_full, w_push, w_pop, w_rd_data, w_rd_stat;
    logic [7:0]    w_off, w_lane;
    logic [15:0]   w_merge;

    // A misaligned word access is decoded as its aligned neighbour.
    assign w_off     = i_be ? i_addr[7:0] : {i_addr[7:1], 1'b0};
    assign w_mmio    = i_addr[15:8] == MMIO_PAGE;
    assign w_accept  = r_state == IDLE && (i_re || i_we);
    assign w_rd_data = w_accept && !i_we && w_mmio && w_off == 8'h00;
    assign w_rd_stat = w_accept && !i_we && w_mmio && w_off == 8'h02;
    assign w_full    = r_cnt == (AW+1)'(RXDEPTH);
    assign w_push    = i_rx_valid && !w_full;
    assign w_pop     = w_rd_data && r_cnt != '0;
    assign w_lane    = r_addr[0] ? i_sram_din[15:8] : i_sram_din[7:0];
    assign w_merge   = r_addr[0] ? {r_wdata[7:0], r_cap[7:0]} : {r_cap[15:8], r_wdata[7:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_we)      w_next = !w_mmio ? (i_be ? RMW_RD : WR) : (w_off == 8'h04 ? TXW : WR);
                else if (i_re) w_next = w_mmio && (w_off == 8'h00 || w_off == 8'h02) ? DONE : RD;
            end
            RMW_RD:  w_next = RMW_WR;
            TXW:     w_next = i_tx_ready ? DONE : TXW;
            DONE:    w_next = IDLE;
            default: w_next = DONE;
        endcase
    end

    // MMIO accesses that pass through RD/WR keep both strobes inactive.
    always_comb begin
        o_rdy       = r_state == IDLE;
        o_ack       = r_state == DONE;
        o_tx_valid  = r_state == TXW;
        o_sram_oe_n = !((r_state == RD || r_state == RMW_RD) && !r_mmio);
        o_sram_we_n = !((r_state == WR || r_state == RMW_WR) && !r_mmio);
        o_sram_dout = r_state == RMW_WR ? w_merge : r_wdata;
        o_sram_addr = r_addr[15:1];
        o_tx_data   = r_wdata[7:0];
        o_rdata     = r_rdata;
        o_align_err = i_rst_n && w_accept && !i_be && i_addr[0];
        o_uart_intr = r_cnt != '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= 1'b0;
            r_mmio  <= 1'b0;
            r_cap   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_be    <= i_be;
                r_mmio  <= w_mmio;
            end
            if (w_rd_data)            r_rdata <= w_pop ? {8'h00, r_fifo[r_rp]} : '0;
            else if (w_rd_stat)       r_rdata <= {13'b0, r_ovf, i_tx_ready, r_cnt != '0};
            else if (r_state == RD)   r_rdata <= r_mmio ? '0 : (r_be ? {8'h00, w_lane} : i_sram_din);
            if (r_state == RMW_RD)    r_cap <= i_sram_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wp] <= i_rx_data;
    end

    // A byte arriving while full is dropped even if a pop happens that cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_ovf <= (r_ovf && !w_rd_stat) || (i_rx_valid && w_full);
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: random and directed accesses checked against a transaction-level
// model of SRAM contents, RX queue, overflow flag and access latencies.
module tb_mem_ctrl;
    localparam int RXD = 4;

    logic        clk = 1'b0, rst_n;
    logic [15:0] addr, wdata, rdata, sram_dout, sram_din;
    logic        re, we, be, rdy, ack, align_err, sram_we_n, sram_oe_n;
    logic [14:0] sram_addr;
    logic [7:0]  rx_data, tx_data;
    logic        rx_valid, tx_valid, tx_ready, uart_intr;

    logic [15:0] sram    [0:32767];
    logic [15:0] ref_mem [0:63];
    logic [7:0]  rq [$];
    logic        rovf;
    int          n_chk = 0, n_fail = 0;

    mem_ctrl #(.RXDEPTH(RXD), .MMIO_PAGE(8'hFF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata), .i_re(re), .i_we(we),
        .i_be(be), .o_rdata(rdata), .o_rdy(rdy), .o_ack(ack), .o_align_err(align_err),
        .o_sram_addr(sram_addr), .o_sram_dout(sram_dout), .i_sram_din(sram_din),
        .o_sram_we_n(sram_we_n), .o_sram_oe_n(sram_oe_n), .i_rx_data(rx_data),
        .i_rx_valid(rx_valid), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready), .o_uart_intr(uart_intr)
    );

    always #5 clk = ~clk;

    assign sram_din = sram[sram_addr];
    always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) chk("strobe_excl", {31'b0, !sram_we_n && !sram_oe_n}, 0);

    task automatic ref_op(input logic [15:0] a, input logic [15:0] d, input logic w, input logic b,
                          output logic [15:0] er, output int el);
        logic [7:0] off;
        logic [5:0] wi;
        off = b ? a[7:0] : {a[7:1], 1'b0};
        wi  = a[6:1];
        er  = '0;
        if (a[15:8] == 8'hFF) begin
            if (w) el = 2;
            else if (off == 8'h00) begin
                el = 1;
                if (rq.size() != 0) er = {8'h00, rq.pop_front()};
            end else if (off == 8'h02) begin
                el = 1;
                er = {13'b0, rovf, tx_ready, rq.size() != 0};
                rovf = 1'b0;
            end else el = 2;
        end else if (w) begin
            if (b) begin
                el = 3;
                if (a[0]) ref_mem[wi][15:8] = d[7:0];
                else      ref_mem[wi][7:0]  = d[7:0];
            end else begin
                el = 2;
                ref_mem[wi] = d;
            end
        end else begin
            el = 2;
            er = b ? {8'h00, a[0] ? ref_mem[wi][15:8] : ref_mem[wi][7:0]} : ref_mem[wi];
        end
    endtask

    task automatic access(input logic [15:0] a, input logic [15:0] d, input logic w, input logic b,
                          input logic push, input logic [7:0] pb);
        logic [15:0] er;
        int el, n;
        logic full;
        full = rq.size() == RXD;
        ref_op(a, d, w, b, er, el);
        if (push) begin
            if (full) rovf = 1'b1;
            else      rq.push_back(pb);
        end
        @(negedge clk);
        chk("rdy", rdy, 1);
        addr = a; wdata = d; we = w; re = !w; be = b; rx_valid = push; rx_data = pb;
        #1 chk("align_err", align_err, !b && a[0]);
        @(posedge clk);
        #1 re = 0; we = 0; rx_valid = 0;
        chk("align_pulse", align_err, 0);
        n = 1;
        while (!ack && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", n, el);
        if (!w) chk("rdata", rdata, er);
        @(posedge clk);
        #1 chk("ack_pulse", ack, 0);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1; rx_data = b;
        if (rq.size() == RXD) rovf = 1'b1;
        else                  rq.push_back(b);
        @(negedge clk);
        rx_valid = 0;
        chk("uart_intr", uart_intr, rq.size() != 0);
    endtask

    initial begin
        logic [15:0] a;
        int nv, r;
        rst_n = 0; addr = 0; wdata = 0; re = 0; we = 0; be = 0;
        rx_data = 0; rx_valid = 0; tx_ready = 1; rovf = 0;
        for (int i = 0; i < 32768; i++) sram[i] = '0;
        for (int i = 0; i < 64; i++) begin
            sram[i] = 16'($urandom);
            ref_mem[i] = sram[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_rdy", rdy, 1);
        chk("rst_rdata", rdata, 0);
        chk("rst_ack", ack, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_intr", uart_intr, 0);
        chk("rst_strobes", {sram_we_n, sram_oe_n}, 2'b11);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_dout", sram_dout, 0);
        chk("rst_tx_data", tx_data, 0);
        rst_n = 1;

        access(16'h0010, 16'hBEEF, 1, 0, 0, 0);
        access(16'h0010, 16'h0000, 0, 0, 0, 0);
        chk("beef_read", rdata, 16'hBEEF);
        access(16'h0011, 16'h0012, 1, 1, 0, 0);
        chk("mem_12ef", sram[8], 16'h12EF);
        access(16'h0011, 16'h0000, 0, 1, 0, 0);
        chk("byte_read", rdata, 16'h0012);
        access(16'h0021, 16'h0000, 0, 0, 0, 0);

        tx_ready = 0;
        for (int i = 0; i < 5; i++) push(8'(8'h41 + i));
        access(16'hFF02, 0, 0, 0, 0, 0);
        chk("stat_ovf", rdata, 16'h0005);
        access(16'hFF02, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            access(16'hFF00, 0, 0, 0, 0, 0);
            chk("intr_after_pop", uart_intr, i < 3);
        end
        access(16'hFF00, 0, 0, 0, 0, 0);

        @(negedge clk);
        addr = 16'hFF04; wdata = 16'h0058; we = 1; be = 0;
        @(posedge clk);
        #1 we = 0;
        nv = 0;
        repeat (3) begin
            @(negedge clk);
            nv += int'(tx_valid);
        end
        @(negedge clk);
        nv += int'(tx_valid);
        chk("tx_data", tx_data, 8'h58);
        chk("tx_ack_wait", ack, 0);
        tx_ready = 1;
        @(posedge clk);
        #1 chk("tx_ack", ack, 1);
        chk("tx_valid_cycles", nv, 4);
        chk("tx_valid_off", tx_valid, 0);
        @(posedge clk);

        access(16'hFF00, 0, 0, 0, 1, 8'h77);
        chk("intr_push_pop_empty", uart_intr, 1);
        access(16'hFF00, 0, 0, 0, 1, 8'h88);
        chk("intr_push_pop", uart_intr, 1);
        access(16'hFF00, 0, 0, 0, 0, 0);

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2) push(8'($urandom));
            else begin
                a = (r < 4) ? {13'h1FE0, 3'($urandom)} : {9'h000, 7'($urandom)};
                access(a, 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, 8'($urandom));
            end
        end

        @(negedge clk);
        addr = 16'h0030; wdata = 16'h00AA; we = 1; be = 1;
        @(posedge clk);
        #1 we = 0;
        chk("rmw_rd_oe", sram_oe_n, 0);
        #1 rst_n = 0;
        #1 chk("abort_we", sram_we_n, 1);
        chk("abort_rdy", rdy, 1);
        @(posedge clk);
        #1 chk("abort_we_edge", sram_we_n, 1);
        @(negedge clk);
        rst_n = 1;
        rq.delete();
        rovf = 0;
        @(negedge clk);
        chk("abort_rdy_after", rdy, 1);
        chk("abort_mem", sram[24], ref_mem[24]);
        chk("abort_rdata", rdata, 0);
        access(16'hFF02, 0, 0, 0, 0, 0);

        for (int i = 0; i < 64; i++) chk("mem_final", sram[i], ref_mem[i]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
